// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: elastic MEM->WB pipeline register with a 2-entry skid buffer.
// Write-back selection and sized load extraction happen at capture time, so
// the stored entry is already the final register-file write value. All state
// advances on the falling clock edge.
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] mem_rdata_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [REG_AW-1:0] rd_addr_in,
    input  logic              reg_w_in,
    input  logic              mem_to_reg_in,
    input  logic [1:0]        mem_size_in,
    input  logic              mem_unsigned_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [REG_AW-1:0] rd_addr_out,
    output logic              reg_w_out,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int SH_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] wb_data;
        logic [REG_AW-1:0] rd_addr;
        logic              reg_w;
    } entry_t;

    state_e            r_state;
    state_e            w_state_nxt;
    entry_t            r_main;
    entry_t            r_skid;
    entry_t            w_new;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_from_in;
    logic              w_main_from_skid;
    logic              w_skid_from_in;
    logic [OFF_W-1:0]  w_off;
    logic [SH_W-1:0]   w_shamt;
    logic [DATA_W-1:0] w_lane;
    logic [DATA_W-1:0] w_load;

    // in_ready comes straight from the state register, so MEM never sees a
    // combinational path from out_ready.
    assign in_ready   = (r_state != S_FULL);
    assign out_valid  = (r_state != S_EMPTY);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    assign w_off = alu_result_in[OFF_W-1:0];

    // Lane shift amount: byte uses the full offset, half drops bit 0, word
    // drops the low two bits (always zero for a 32-bit datapath).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_shamt = '0;
        case (mem_size_in)
            2'b00:   w_shamt = {w_off, 3'b000};
            2'b01:   w_shamt = {w_off & ~OFF_W'(1), 3'b000};
            2'b10:   w_shamt = {w_off & ~OFF_W'(3), 3'b000};
            default: w_shamt = '0;
        endcase
    end

    assign w_lane = mem_rdata_in >> w_shamt;

    // Sign/zero extension: prepend the extension bit, then let the signed
    // cast replicate it up to DATA_W.
    always_comb begin
        w_load = w_lane;
        case (mem_size_in)
            2'b00:   w_load = DATA_W'($signed({~mem_unsigned_in & w_lane[7],  w_lane[7:0]}));
            2'b01:   w_load = DATA_W'($signed({~mem_unsigned_in & w_lane[15], w_lane[15:0]}));
            2'b10:   w_load = DATA_W'($signed({~mem_unsigned_in & w_lane[31], w_lane[31:0]}));
            default: w_load = w_lane;
        endcase
    end

    assign w_new.wb_data = mem_to_reg_in ? w_load : alu_result_in;
    assign w_new.rd_addr = rd_addr_in;
    assign w_new.reg_w   = reg_w_in & (rd_addr_in != '0);

    // Next-state and slot-load decisions; flush overrides everything.
    always_comb begin
        w_state_nxt      = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt    = S_ONE;
                        w_main_from_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_from_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt    = S_FULL;
                        w_skid_from_in = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt      = S_ONE;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(negedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) r_state <= S_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Payload slots; both are cleared on reset so outputs read zero.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_main_from_in)        r_main <= w_new;
            else if (w_main_from_skid) r_main <= r_skid;
            if (w_skid_from_in)        r_skid <= w_new;
        end
    end

    assign wb_data_out = r_main.wb_data;
    assign rd_addr_out = r_main.rd_addr;
    assign reg_w_out   = r_main.reg_w;
    assign fwd_valid   = out_valid & r_main.reg_w;
    assign fwd_rd      = r_main.rd_addr;
    assign fwd_data    = r_main.wb_data;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed testbench for mem_wb_pipe (DATA_W=32). Inputs change and outputs
// are sampled 1 time unit after each falling (active) edge.
module tb_mem_wb_pipe;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] mem_rdata_in;
    logic [DATA_W-1:0] alu_result_in;
    logic [REG_AW-1:0] rd_addr_in;
    logic              reg_w_in;
    logic              mem_to_reg_in;
    logic [1:0]        mem_size_in;
    logic              mem_unsigned_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] wb_data_out;
    logic [REG_AW-1:0] rd_addr_out;
    logic              reg_w_out;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [DATA_W-1:0] fwd_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_wb_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_rdata_in(mem_rdata_in), .alu_result_in(alu_result_in),
        .rd_addr_in(rd_addr_in), .reg_w_in(reg_w_in),
        .mem_to_reg_in(mem_to_reg_in), .mem_size_in(mem_size_in),
        .mem_unsigned_in(mem_unsigned_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data_out(wb_data_out), .rd_addr_out(rd_addr_out),
        .reg_w_out(reg_w_out), .fwd_valid(fwd_valid),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic [DATA_W-1:0] alu, input logic [REG_AW-1:0] rd);
        in_valid        = 1'b1;
        alu_result_in   = alu;
        rd_addr_in      = rd;
        reg_w_in        = 1'b1;
        mem_to_reg_in   = 1'b0;
        mem_size_in     = 2'b10;
        mem_unsigned_in = 1'b0;
        mem_rdata_in    = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mem_rdata_in = '0; alu_result_in = '0; rd_addr_in = '0; reg_w_in = 1'b0;
        mem_to_reg_in = 1'b0; mem_size_in = 2'b00; mem_unsigned_in = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        n_vec++; if (wb_data_out !== 32'h0) begin n_err++; $display("FAIL reset wb_data got %h want 0", wb_data_out); end
        n_vec++; if (rd_addr_out !== 5'd0 || reg_w_out !== 1'b0 || fwd_valid !== 1'b0) begin
            n_err++; $display("FAIL reset rd/reg_w/fwd got %0d/%b/%b want 0/0/0", rd_addr_out, reg_w_out, fwd_valid);
        end
    endtask

    task automatic test_alu_single();
        out_ready = 1'b1;
        drive_alu(32'h0000_1234, 5'd5);
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL alu out_valid got %b want 1", out_valid); end
        n_vec++; if (wb_data_out !== 32'h0000_1234) begin n_err++; $display("FAIL alu wb_data got %h want 00001234", wb_data_out); end
        n_vec++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h0000_1234) begin
            n_err++; $display("FAIL alu fwd got %b/%0d/%h want 1/5/00001234", fwd_valid, fwd_rd, fwd_data);
        end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL alu drain out_valid got %b want 0", out_valid); end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  off;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp;
    } load_vec_t;

    task automatic test_loads();
        load_vec_t v[11];
        v[0]  = '{32'h80FF_7F01, 2'd3, 2'b00, 1'b0, 32'hFFFF_FF80};
        v[1]  = '{32'h80FF_7F01, 2'd3, 2'b00, 1'b1, 32'h0000_0080};
        v[2]  = '{32'h80FF_7F01, 2'd2, 2'b01, 1'b0, 32'hFFFF_80FF};
        v[3]  = '{32'h80FF_7F01, 2'd0, 2'b00, 1'b0, 32'h0000_0001};
        v[4]  = '{32'h80FF_7F01, 2'd1, 2'b00, 1'b0, 32'h0000_007F};
        v[5]  = '{32'h80FF_7F01, 2'd2, 2'b00, 1'b0, 32'hFFFF_FFFF};
        v[6]  = '{32'h80FF_7F01, 2'd2, 2'b00, 1'b1, 32'h0000_00FF};
        v[7]  = '{32'h80FF_7F01, 2'd0, 2'b01, 1'b0, 32'h0000_7F01};
        v[8]  = '{32'h80FF_7F01, 2'd3, 2'b01, 1'b1, 32'h0000_80FF};
        v[9]  = '{32'h80FF_7F01, 2'd2, 2'b10, 1'b0, 32'h80FF_7F01};
        v[10] = '{32'h80FF_7F01, 2'd1, 2'b11, 1'b1, 32'h80FF_7F01};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid        = 1'b1;
            mem_rdata_in    = v[i].rdata;
            alu_result_in   = {28'h0000_100, 2'b00, v[i].off};
            rd_addr_in      = 5'd7;
            reg_w_in        = 1'b1;
            mem_to_reg_in   = 1'b1;
            mem_size_in     = v[i].size;
            mem_unsigned_in = v[i].uns;
            tick();
            n_vec++; if (out_valid !== 1'b1 || wb_data_out !== v[i].exp) begin
                n_err++; $display("FAIL load[%0d] valid/wb_data got %b/%h want 1/%h", i, out_valid, wb_data_out, v[i].exp);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive_alu(32'h11, 5'd1); tick();
        n_vec++; if (out_valid !== 1'b1 || wb_data_out !== 32'h11 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b A valid/wb/in_ready got %b/%h/%b want 1/11/1", out_valid, wb_data_out, in_ready);
        end
        drive_alu(32'h22, 5'd2); tick();
        n_vec++; if (wb_data_out !== 32'h11 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b full wb/in_ready got %h/%b want 11/0", wb_data_out, in_ready);
        end
        drive_alu(32'h33, 5'd3); tick();
        n_vec++; if (wb_data_out !== 32'h11 || rd_addr_out !== 5'd1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b stall wb/rd/in_ready got %h/%0d/%b want 11/1/0", wb_data_out, rd_addr_out, in_ready);
        end
        out_ready = 1'b1; tick();
        n_vec++; if (out_valid !== 1'b1 || wb_data_out !== 32'h22 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b B valid/wb/in_ready got %b/%h/%b want 1/22/1", out_valid, wb_data_out, in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || wb_data_out !== 32'h33 || rd_addr_out !== 5'd3) begin
            n_err++; $display("FAIL b2b C valid/wb/rd got %b/%h/%0d want 1/33/3", out_valid, wb_data_out, rd_addr_out);
        end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b drain out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive_alu(32'hA1, 5'd4); tick();
        drive_alu(32'hB2, 5'd6); tick();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush prefill in_ready got %b want 0", in_ready); end
        drive_alu(32'hD4, 5'd8);
        flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL flush valid/in_ready got %b/%b want 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1; tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush dropped entry out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_rd_zero();
        out_ready = 1'b0;
        drive_alu(32'h55, 5'd0); tick();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || reg_w_out !== 1'b0 || fwd_valid !== 1'b0 || wb_data_out !== 32'h55) begin
            n_err++; $display("FAIL rd0 valid/reg_w/fwd/wb got %b/%b/%b/%h want 1/0/0/55", out_valid, reg_w_out, fwd_valid, wb_data_out);
        end
        out_ready = 1'b1; tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rd0 drain out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive_alu(32'h77, 5'd9); tick();
        drive_alu(32'h88, 5'd10); tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || wb_data_out !== 32'h0 || rd_addr_out !== 5'd0 || fwd_valid !== 1'b0) begin
            n_err++; $display("FAIL async_rst valid/in_ready/wb/rd/fwd got %b/%b/%h/%0d/%b want 0/1/0/0/0",
                              out_valid, in_ready, wb_data_out, rd_addr_out, fwd_valid);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_rst post out_valid got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_loads();
        test_back_to_back();
        test_flush();
        test_rd_zero();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
